// File: rtl/cross_bar_nxm.sv
// N-master x M-slave request/ack crossbar with a per-slave arbiter (fixed or
// round-robin), owner locking until slave ack, registered read return and decode-error responder.
module cross_bar_nxm #(
   parameter int                N_MASTER = 4,
   parameter int                N_SLAVE  = 4,
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                ARB_MODE = 1,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_MASTER-1:0]          m_req,
   input  logic [N_MASTER*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTER-1:0]          m_cmd,
   input  logic [N_MASTER*DATA_W-1:0]   m_wdata,
   output logic [N_MASTER-1:0]          m_ack,
   output logic [N_MASTER*DATA_W-1:0]   m_rdata,
   output logic [N_MASTER-1:0]          m_rvalid,
   output logic [N_SLAVE-1:0]           s_req,
   output logic [N_SLAVE*ADDR_W-1:0]    s_addr,
   output logic [N_SLAVE-1:0]           s_cmd,
   output logic [N_SLAVE*DATA_W-1:0]    s_wdata,
   input  logic [N_SLAVE-1:0]           s_ack,
   input  logic [N_SLAVE*DATA_W-1:0]    s_rdata
);

   localparam int SEL_W = $clog2(N_SLAVE);
   localparam int MW    = $clog2(N_MASTER);

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   arb_state_t          state_q   [N_SLAVE];
   arb_state_t          state_d   [N_SLAVE];
   logic [MW-1:0]       owner_q   [N_SLAVE];
   logic [MW-1:0]       rr_ptr_q  [N_SLAVE];
   logic [MW-1:0]       rsp_own_q [N_SLAVE];
   logic [N_SLAVE-1:0]  rsp_vld_q;
   logic [N_MASTER-1:0] err_rsp_q;

   logic [SEL_W-1:0]    tgt       [N_MASTER];
   logic [N_MASTER-1:0] dec_err;
   logic [N_SLAVE-1:0]  gnt_vld;
   logic [MW-1:0]       gnt_idx   [N_SLAVE];
   logic [MW-1:0]       start;
   logic [MW-1:0]       cand;
   logic                found;

   always_comb begin
      for (int unsigned i = 0; i < N_MASTER; i++) begin
         tgt[i]     = m_addr[i*ADDR_W + ADDR_W - 1 -: SEL_W];
         dec_err[i] = 32'(tgt[i]) >= 32'(N_SLAVE);
      end
   end

   always_comb begin
      start = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned j = 0; j < N_SLAVE; j++) begin
         gnt_vld[j] = 1'b0;
         gnt_idx[j] = '0;
         state_d[j] = state_q[j];
         if (state_q[j] == LOCKED) begin
            // An owner that drops its request or retargets loses the lock without an ack.
            if (m_req[owner_q[j]] && !dec_err[owner_q[j]] && 32'(tgt[owner_q[j]]) == j) begin
               gnt_vld[j] = 1'b1;
               gnt_idx[j] = owner_q[j];
               if (s_ack[j]) state_d[j] = IDLE;
            end else begin
               state_d[j] = IDLE;
            end
         end else begin
            start = (ARB_MODE != 0) ? rr_ptr_q[j] : '0;
            found = 1'b0;
            for (int unsigned k = 0; k < N_MASTER; k++) begin
               cand = MW'((32'(start) + k) % 32'(N_MASTER));
               if (!found && m_req[cand] && !dec_err[cand] && 32'(tgt[cand]) == j) begin
                  found      = 1'b1;
                  gnt_vld[j] = 1'b1;
                  gnt_idx[j] = cand;
               end
            end
            if (found && !s_ack[j]) state_d[j] = LOCKED;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned j = 0; j < N_SLAVE; j++) begin
            state_q[j]   <= IDLE;
            owner_q[j]   <= '0;
            rr_ptr_q[j]  <= '0;
            rsp_own_q[j] <= '0;
         end
         rsp_vld_q <= '0;
         err_rsp_q <= '0;
      end else begin
         for (int unsigned j = 0; j < N_SLAVE; j++) begin
            state_q[j] <= state_d[j];
            if (state_q[j] == IDLE) owner_q[j] <= gnt_idx[j];
            if (gnt_vld[j] && s_ack[j] && ARB_MODE != 0)
               rr_ptr_q[j] <= MW'((32'(gnt_idx[j]) + 1) % 32'(N_MASTER));
            rsp_vld_q[j] <= gnt_vld[j] && s_ack[j] && !m_cmd[gnt_idx[j]];
            rsp_own_q[j] <= gnt_idx[j];
         end
         err_rsp_q <= m_req & dec_err & ~m_cmd;
      end
   end

   always_comb begin
      s_req    = '0;
      s_addr   = '0;
      s_cmd    = '0;
      s_wdata  = '0;
      m_ack    = '0;
      m_rdata  = '0;
      m_rvalid = '0;
      if (!reset) begin
         for (int unsigned j = 0; j < N_SLAVE; j++) begin
            if (gnt_vld[j]) begin
               s_req[j]                     = 1'b1;
               s_addr[j*ADDR_W +: ADDR_W]   = m_addr[32'(gnt_idx[j])*ADDR_W +: ADDR_W];
               s_cmd[j]                     = m_cmd[gnt_idx[j]];
               s_wdata[j*DATA_W +: DATA_W]  = m_wdata[32'(gnt_idx[j])*DATA_W +: DATA_W];
               if (s_ack[j]) m_ack[gnt_idx[j]] = 1'b1;
            end
            if (rsp_vld_q[j]) begin
               m_rvalid[rsp_own_q[j]]                         = 1'b1;
               m_rdata[32'(rsp_own_q[j])*DATA_W +: DATA_W]    = s_rdata[j*DATA_W +: DATA_W];
            end
         end
         m_ack = m_ack | (m_req & dec_err);
         for (int unsigned i = 0; i < N_MASTER; i++) begin
            if (err_rsp_q[i]) begin
               m_rvalid[i]                = 1'b1;
               m_rdata[i*DATA_W +: DATA_W] = ERR_DATA;
            end
         end
      end
   end

endmodule

// File: tb/tb_cross_bar_nxm.sv
// Directed bench for cross_bar_nxm: a 4x4 instance plus a 4x3 instance for decode errors.
module tb_cross_bar_nxm;

   logic         clk = 1'b0;
   logic         reset;
   always #5 clk = ~clk;

   logic [3:0]   m_req, m_cmd, m_ack, m_rvalid;
   logic [127:0] m_addr, m_wdata, m_rdata;
   logic [3:0]   s_req, s_cmd, s_ack;
   logic [127:0] s_addr, s_wdata, s_rdata;

   logic [3:0]   e_m_req, e_m_cmd, e_m_ack, e_m_rvalid;
   logic [127:0] e_m_addr, e_m_wdata, e_m_rdata;
   logic [2:0]   e_s_req, e_s_cmd, e_s_ack;
   logic [95:0]  e_s_addr, e_s_wdata, e_s_rdata;

   int checks   = 0;
   int failures = 0;

   cross_bar_nxm #(.N_MASTER(4), .N_SLAVE(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut (
      .clk(clk), .reset(reset),
      .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
      .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
      .s_ack(s_ack), .s_rdata(s_rdata)
   );

   cross_bar_nxm #(.N_MASTER(4), .N_SLAVE(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut3 (
      .clk(clk), .reset(reset),
      .m_req(e_m_req), .m_addr(e_m_addr), .m_cmd(e_m_cmd), .m_wdata(e_m_wdata),
      .m_ack(e_m_ack), .m_rdata(e_m_rdata), .m_rvalid(e_m_rvalid),
      .s_req(e_s_req), .s_addr(e_s_addr), .s_cmd(e_s_cmd), .s_wdata(e_s_wdata),
      .s_ack(e_s_ack), .s_rdata(e_s_rdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_all();
      m_req = '0; m_addr = '0; m_cmd = '0; m_wdata = '0; s_ack = '0;
      e_m_req = '0; e_m_addr = '0; e_m_cmd = '0; e_m_wdata = '0; e_s_ack = '0;
   endtask

   task automatic set_m(input int i, input logic [31:0] a, input logic c, input logic [31:0] d);
      m_req[i]          = 1'b1;
      m_addr[i*32 +: 32] = a;
      m_cmd[i]          = c;
      m_wdata[i*32 +: 32] = d;
   endtask

   initial begin
      reset = 1'b1;
      idle_all();
      s_rdata   = '0;
      e_s_rdata = '0;

      // Outputs forced low while reset is held, even with a live request
      @(negedge clk);
      set_m(0, 32'h4000_0010, 1'b0, 32'h0);
      s_ack = 4'b0010;
      #1;
      check("rst_sreq",   64'(s_req),    64'h0);
      check("rst_mack",   64'(m_ack),    64'h0);
      check("rst_rvalid", 64'(m_rvalid), 64'h0);
      check("rst_saddr",  64'(s_addr[63:32]), 64'h0);

      // Single read M0 -> slave 1
      @(negedge clk);
      reset = 1'b0;
      idle_all();
      set_m(0, 32'h4000_0010, 1'b0, 32'h0);
      s_ack = 4'b0010;
      #1;
      check("rd_sreq",  64'(s_req),          64'h2);
      check("rd_saddr", 64'(s_addr[63:32]),  64'h4000_0010);
      check("rd_mack",  64'(m_ack),          64'h1);
      @(negedge clk);
      idle_all();
      s_rdata[63:32] = 32'h1234_5678;
      #1;
      check("rd_rvalid", 64'(m_rvalid),        64'h1);
      check("rd_rdata",  64'(m_rdata[31:0]),   64'h1234_5678);
      check("rd_rdata1", 64'(m_rdata[63:32]),  64'h0);
      @(negedge clk);
      #1;
      check("rd_rvalid_off", 64'(m_rvalid), 64'h0);
      check("rd_rdata_off",  64'(m_rdata),  64'h0);

      // Round-robin on slave 2, all masters writing, ack tied high
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         idle_all();
         for (int i = 0; i < 4; i++) set_m(i, 32'h8000_0000 | 32'(i << 4), 1'b1, 32'h1000 + 32'(i));
         s_ack = 4'b0100;
         #1;
         check("rr_ack",   64'(m_ack),           64'(1 << (c % 4)));
         check("rr_wdata", 64'(s_wdata[95:64]),  64'(32'h1000 + 32'(c % 4)));
      end

      // Lock on slave 0: M2 holds the slave until acked, then M0
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         idle_all();
         if (c < 5)  set_m(2, 32'h0000_0200, 1'b1, 32'h0);
         if (c >= 3) set_m(0, 32'h0000_0040, 1'b1, 32'h0);
         s_ack = (c >= 4) ? 4'b0001 : 4'b0000;
         #1;
         if (c < 4) begin
            check("lk_saddr", 64'(s_addr[31:0]), 64'h200);
            check("lk_mack",  64'(m_ack),        64'h0);
         end else if (c == 4) begin
            check("lk_saddr_ack", 64'(s_addr[31:0]), 64'h200);
            check("lk_mack_m2",   64'(m_ack),        64'h4);
         end else begin
            check("lk_saddr_m0", 64'(s_addr[31:0]), 64'h40);
            check("lk_mack_m0",  64'(m_ack),        64'h1);
         end
      end

      // Back-to-back reads by M3: slave 0 then slave 3
      @(negedge clk);
      idle_all();
      set_m(3, 32'h0000_0300, 1'b0, 32'h0);
      s_ack = 4'b0001;
      #1;
      check("bb_ack0", 64'(m_ack), 64'h8);
      @(negedge clk);
      idle_all();
      set_m(3, 32'hC000_0300, 1'b0, 32'h0);
      s_ack = 4'b1000;
      s_rdata[31:0] = 32'hAAAA_0000;
      #1;
      check("bb_ack3",    64'(m_ack),            64'h8);
      check("bb_rvalid0", 64'(m_rvalid),         64'h8);
      check("bb_rdata0",  64'(m_rdata[127:96]),  64'hAAAA_0000);
      @(negedge clk);
      idle_all();
      s_rdata[127:96] = 32'hBBBB_3333;
      #1;
      check("bb_rvalid3", 64'(m_rvalid),         64'h8);
      check("bb_rdata3",  64'(m_rdata[127:96]),  64'hBBBB_3333);
      @(negedge clk);
      #1;
      check("bb_rvalid_off", 64'(m_rvalid), 64'h0);

      // Decode error on the 3-slave instance
      @(negedge clk);
      idle_all();
      e_m_req[1] = 1'b1;
      e_m_addr[63:32] = 32'hC000_0000;
      e_m_cmd[1] = 1'b0;
      #1;
      check("de_ack",  64'(e_m_ack), 64'h2);
      check("de_sreq", 64'(e_s_req), 64'h0);
      @(negedge clk);
      idle_all();
      e_m_req[1] = 1'b1;
      e_m_addr[63:32] = 32'hC000_0000;
      e_m_cmd[1] = 1'b1;
      #1;
      check("de_rvalid", 64'(e_m_rvalid),       64'h2);
      check("de_rdata",  64'(e_m_rdata[63:32]), 64'hDEAD_BEEF);
      check("de_wack",   64'(e_m_ack),          64'h2);
      check("de_wsreq",  64'(e_s_req),          64'h0);
      @(negedge clk);
      idle_all();
      #1;
      check("de_wr_norv", 64'(e_m_rvalid), 64'h0);

      // Reset while slave 0 is locked and a slave-1 read return is pending
      @(negedge clk);
      idle_all();
      set_m(1, 32'h4000_0100, 1'b0, 32'h0);
      set_m(2, 32'h0000_0200, 1'b1, 32'h0);
      s_ack = 4'b0010;
      s_rdata[63:32] = 32'h5555_1111;
      #1;
      check("ra_mack", 64'(m_ack), 64'h2);
      @(negedge clk);
      reset = 1'b1;
      idle_all();
      set_m(2, 32'h0000_0200, 1'b1, 32'h0);
      #1;
      check("ra_rvalid", 64'(m_rvalid), 64'h0);
      check("ra_rdata",  64'(m_rdata[63:32]), 64'h0);
      check("ra_sreq",   64'(s_req),    64'h0);
      check("ra_saddr",  64'(s_addr[31:0]), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      idle_all();
      set_m(0, 32'h4000_0000, 1'b1, 32'h0);
      set_m(3, 32'h4000_0030, 1'b1, 32'h0);
      set_m(1, 32'h0000_0100, 1'b1, 32'h0);
      set_m(2, 32'h0000_0200, 1'b1, 32'h0);
      s_ack = 4'b0011;
      #1;
      check("ra_post_rvalid", 64'(m_rvalid),       64'h0);
      check("ra_post_mack",   64'(m_ack),          64'h3);
      check("ra_post_saddr0", 64'(s_addr[31:0]),   64'h100);
      check("ra_post_saddr1", 64'(s_addr[63:32]),  64'h4000_0000);
      @(negedge clk);
      idle_all();
      #1;
      check("ra_end_rvalid", 64'(m_rvalid), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
